// File: rtl/decoder_stage_controller.sv
// Decoder stage controller: sequences one decode round through the shared stage
// encoding broadcast to all processing units (PUs).
//
//   IDLE -> MEASUREMENT_LOADING (2 cycles) -> GROW (1 cycle) -> MERGE
//   MERGE -> GROW while odd clusters remain and iterations are left
//   MERGE -> PEELING once no odd clusters remain, or on iteration overflow
//   PEELING -> RESULT_VALID -> IDLE on result_ack
//
// MERGE and PEELING end after SETTLE_CYCLES consecutive quiet cycles. Busy is
// blanked for the first two cycles of each of these states because the PU busy
// flags lag the stage broadcast by the PU register stage.
//
// Optional feature: define DECODE_CYCLE_COUNT_EN to build the decode-latency
// counter on cycle_count; otherwise cycle_count is tied to zero.
//
// Reset is synchronous and active-high.

module decoder_stage_controller #(
   parameter int unsigned PU_COUNT      = 100,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned MAX_ITER      = 15,
   parameter int unsigned ITER_WIDTH    = 4,
   parameter int unsigned CYCLE_WIDTH   = 16,
   localparam int unsigned STAGE_WIDTH  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PU_COUNT-1:0]    busy,
   input  logic [PU_COUNT-1:0]    odd,
   input  logic                   result_ack,
   output logic [STAGE_WIDTH-1:0] global_stage,
   output logic                   result_valid,
   output logic [ITER_WIDTH-1:0]  iteration_count,
   output logic                   iter_overflow,
   output logic [CYCLE_WIDTH-1:0] cycle_count
);

   // Shared stage encoding, as decoded by every PU.
   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
   localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

   typedef enum logic [STAGE_WIDTH-1:0] {
      StIdle        = STAGE_IDLE,
      StLoad        = STAGE_MEASUREMENT_LOADING,
      StGrow        = STAGE_GROW,
      StMerge       = STAGE_MERGE,
      StPeel        = STAGE_PEELING,
      StResultValid = STAGE_RESULT_VALID
   } stage_e;

   localparam int unsigned QuietWidth =
      (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [QuietWidth-1:0] QuietMax  = QuietWidth'(SETTLE_CYCLES);
   localparam logic [ITER_WIDTH-1:0] IterMax   = ITER_WIDTH'(MAX_ITER);
   // Cycles after MERGE/PEELING entry during which busy is not yet trustworthy.
   localparam logic [1:0]            BlankLast = 2'd2;

   stage_e                  state_q, state_d;
   logic [1:0]              dwell_q, dwell_d;
   logic [QuietWidth-1:0]   quiet_q, quiet_d;
   logic [QuietWidth-1:0]   quiet_next;
   logic [ITER_WIDTH-1:0]   iter_q, iter_d;
   logic                    ovf_q, ovf_d;

   logic                    busy_any;
   logic                    odd_any;
   logic                    settle_state;
   logic                    blanked;
   logic                    settled;

   assign busy_any     = |busy;
   assign odd_any      = |odd;
   assign settle_state = (state_q == StMerge) || (state_q == StPeel);
   assign blanked      = (dwell_q < BlankLast);

   // Quiet counter candidate for staying in the current state.
   always_comb begin
      quiet_next = '0;
      settled    = 1'b0;
      if (settle_state && !blanked && !busy_any) begin
         if (quiet_q == QuietMax) begin
            quiet_next = quiet_q;
         end else begin
            quiet_next = quiet_q + 1'b1;
         end
         // Exit in the cycle the counter reaches its target, not one later.
         settled = (quiet_next == QuietMax);
      end
   end

   // Stage sequencing and round bookkeeping.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               iter_d  = '0;
               ovf_d   = 1'b0;
            end
         end

         StLoad: begin
            if (dwell_q == 2'd1) begin
               state_d = StGrow;
            end
         end

         StGrow: begin
            if (iter_q != IterMax) begin
               iter_d = iter_q + 1'b1;
            end
            state_d = StMerge;
         end

         StMerge: begin
            if (settled) begin
               if (!odd_any) begin
                  state_d = StPeel;
               end else if (iter_q < IterMax) begin
                  state_d = StGrow;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = StPeel;
               end
            end
         end

         StPeel: begin
            if (settled) begin
               state_d = StResultValid;
            end
         end

         StResultValid: begin
            if (result_ack) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Dwell and quiet counters restart on every stage change.
   always_comb begin
      dwell_d = dwell_q;
      quiet_d = quiet_next;
      if (state_d != state_q) begin
         dwell_d = '0;
         quiet_d = '0;
      end else if (dwell_q != BlankLast) begin
         dwell_d = dwell_q + 1'b1;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         dwell_q <= '0;
         quiet_q <= '0;
         iter_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         quiet_q <= quiet_d;
         iter_q  <= iter_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef DECODE_CYCLE_COUNT_EN
   logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
   logic                   counting;

   assign counting = (state_q == StLoad) || (state_q == StGrow) ||
                     (state_q == StMerge) || (state_q == StPeel);

   // Decode latency: cleared on accepted start, saturating, held after the round.
   always_comb begin
      cycle_d = cycle_q;
      if ((state_q == StIdle) && start) begin
         cycle_d = '0;
      end else if (counting && (cycle_q != {CYCLE_WIDTH{1'b1}})) begin
         cycle_d = cycle_q + 1'b1;
      end
   end

   // Latency counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   assign cycle_count = cycle_q;
`else
   assign cycle_count = '0;
`endif

   assign global_stage    = state_q;
   assign result_valid    = (state_q == StResultValid);
   assign iteration_count = iter_q;
   assign iter_overflow   = ovf_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for decoder_stage_controller. A second instance with
// MAX_ITER = 2 exercises the iteration-overflow path.

module tb_decoder_stage_controller;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_GROW  = 3'd2;
   localparam logic [2:0] S_MERGE = 3'd3;
   localparam logic [2:0] S_PEEL  = 3'd4;
   localparam logic [2:0] S_RV    = 3'd5;

`ifdef DECODE_CYCLE_COUNT_EN
   localparam int unsigned ExpCycles = 13;
`else
   localparam int unsigned ExpCycles = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start, result_ack;
   logic [99:0] busy, odd;
   logic [2:0]  global_stage;
   logic        result_valid;
   logic [3:0]  iteration_count;
   logic        iter_overflow;
   logic [15:0] cycle_count;

   logic        start2, ack2;
   logic [7:0]  busy2, odd2;
   logic [2:0]  stage2;
   logic        rv2;
   logic [3:0]  iter2;
   logic        ovf2;
   logic [15:0] cyc2;

   decoder_stage_controller u_dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .busy            (busy),
      .odd             (odd),
      .result_ack      (result_ack),
      .global_stage    (global_stage),
      .result_valid    (result_valid),
      .iteration_count (iteration_count),
      .iter_overflow   (iter_overflow),
      .cycle_count     (cycle_count)
   );

   decoder_stage_controller #(
      .PU_COUNT (8),
      .MAX_ITER (2)
   ) u_dut_ovf (
      .clk             (clk),
      .reset           (reset),
      .start           (start2),
      .busy            (busy2),
      .odd             (odd2),
      .result_ack      (ack2),
      .global_stage    (stage2),
      .result_valid    (rv2),
      .iteration_count (iter2),
      .iter_overflow   (ovf2),
      .cycle_count     (cyc2)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [2:0] exp_seq [14];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int grows;
      int n;
      logic [2:0] prev;

      exp_seq = '{S_LOAD, S_LOAD, S_GROW, S_MERGE, S_MERGE, S_MERGE, S_MERGE, S_MERGE,
                  S_PEEL, S_PEEL, S_PEEL, S_PEEL, S_PEEL, S_RV};

      reset = 1'b1; start = 1'b0; result_ack = 1'b0; busy = '0; odd = '0;
      start2 = 1'b0; ack2 = 1'b0; busy2 = '0; odd2 = '0;
      step();
      step();
      reset = 1'b0;
      check_eq("rst_stage", 32'(global_stage), 32'(S_IDLE));
      check_eq("rst_rv", 32'(result_valid), 0);
      check_eq("rst_iter", 32'(iteration_count), 0);
      check_eq("rst_ovf", 32'(iter_overflow), 0);
      check_eq("rst_cyc", 32'(cycle_count), 0);
      check_eq("rst_stage2", 32'(stage2), 32'(S_IDLE));

      // Quiet round: full stage sequence.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         check_eq($sformatf("t1_seq%0d", i), 32'(global_stage), 32'(exp_seq[i]));
         if (i < 13) step();
      end
      check_eq("t1_rv", 32'(result_valid), 1);
      check_eq("t1_iter", 32'(iteration_count), 1);
      check_eq("t1_ovf", 32'(iter_overflow), 0);
      check_eq("t1_cyc", 32'(cycle_count), ExpCycles);

      // Result held without ack; start during RESULT_VALID ignored.
      for (int k = 0; k < 4; k++) begin
         start = (k == 1);
         check_eq($sformatf("t1_hold_rv%0d", k), 32'(result_valid), 1);
         step();
      end
      start = 1'b0;
      check_eq("t1_hold_stage", 32'(global_stage), 32'(S_RV));
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      check_eq("t1_ack_idle", 32'(global_stage), 32'(S_IDLE));
      check_eq("t1_ack_rv", 32'(result_valid), 0);
      check_eq("t1_iter_held", 32'(iteration_count), 1);
      check_eq("t1_cyc_held", 32'(cycle_count), ExpCycles);

      // odd[7] high through two MERGE exits.
      start = 1'b1;
      odd[7] = 1'b1;
      step();
      start = 1'b0;
      check_eq("t3_iter_clr", 32'(iteration_count), 0);
      grows = 0;
      prev = S_LOAD;
      for (int i = 0; i < 200 && global_stage != S_RV; i++) begin
         if (global_stage == S_GROW && prev != S_GROW) begin
            grows++;
            if (grows == 3) odd[7] = 1'b0;
         end
         prev = global_stage;
         step();
      end
      check_eq("t3_reach_rv", 32'(global_stage), 32'(S_RV));
      check_eq("t3_grows", 32'(grows), 3);
      check_eq("t3_iter", 32'(iteration_count), 3);
      check_eq("t3_ovf", 32'(iter_overflow), 0);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;

      // busy[3] toggling in MERGE, then quiet.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20 && global_stage != S_MERGE; i++) step();
      check_eq("t4_reach_merge", 32'(global_stage), 32'(S_MERGE));
      for (int c = 1; c <= 10; c++) begin
         busy[3] = (c % 2 == 0);
         step();
      end
      busy[3] = 1'b0;
      check_eq("t4_still_merge", 32'(global_stage), 32'(S_MERGE));
      n = 0;
      for (int i = 0; i < 20 && global_stage == S_MERGE; i++) begin
         n++;
         step();
      end
      check_eq("t4_settle_len", 32'(n), 3);
      check_eq("t4_to_peel", 32'(global_stage), 32'(S_PEEL));

      // Reset together with start in PEELING.
      step();
      check_eq("t5_in_peel", 32'(global_stage), 32'(S_PEEL));
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check_eq("t5_stage", 32'(global_stage), 32'(S_IDLE));
      check_eq("t5_rv", 32'(result_valid), 0);
      check_eq("t5_iter", 32'(iteration_count), 0);
      check_eq("t5_ovf", 32'(iter_overflow), 0);
      check_eq("t5_cyc", 32'(cycle_count), 0);
      step();
      check_eq("t5_start_dropped", 32'(global_stage), 32'(S_IDLE));

      // Overflow with MAX_ITER = 2 and odd stuck high.
      start2 = 1'b1;
      odd2[0] = 1'b1;
      step();
      start2 = 1'b0;
      grows = 0;
      prev = S_LOAD;
      for (int i = 0; i < 200 && stage2 != S_PEEL; i++) begin
         if (stage2 == S_GROW && prev != S_GROW) grows++;
         prev = stage2;
         step();
      end
      check_eq("t6_reach_peel", 32'(stage2), 32'(S_PEEL));
      check_eq("t6_grows", 32'(grows), 2);
      check_eq("t6_ovf", 32'(ovf2), 1);
      check_eq("t6_iter", 32'(iter2), 2);
      for (int i = 0; i < 50 && stage2 != S_RV; i++) step();
      check_eq("t6_reach_rv", 32'(rv2), 1);
      ack2 = 1'b1;
      step();
      ack2 = 1'b0;
      check_eq("t6_idle", 32'(stage2), 32'(S_IDLE));
      check_eq("t6_ovf_held", 32'(ovf2), 1);
      check_eq("t6_iter_held", 32'(iter2), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
